lna_power_sequencer: RTL

//  Parametrised per-channel LNA/PA supply sequencer for the RF front end, generalising the single

---
 rtl/lna_seq_pkg.sv | 28 ++
 rtl/lna_power_sequencer_if.sv | 34 +++
 rtl/lna_chan_fsm.sv | 130 +++++++++++++
 rtl/lna_power_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/lna_seq_pkg.sv
// Shared definitions for the LNA/PA supply sequencer.
//  - chan_state_t : per-channel FSM state, 3-bit encoding (also exported on the debug bus)
//  - DEF_*        : default channel count, counter width, settle and guard lengths
//  - cycles_fit   : true when a cycle count can be loaded (as count-1) into a cnt_w counter
package lna_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RX_RAMP = 3'd1,
    ST_RX_ON   = 3'd2,
    ST_TX_RAMP = 3'd3,
    ST_TX_ON   = 3'd4,
    ST_GUARD   = 3'd5
  } chan_state_t;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_RX_SETTLE = 16;
  localparam int DEF_TX_SETTLE = 24;
  localparam int DEF_GUARD     = 4;

  function automatic bit cycles_fit(input int cycles, input int cnt_w);
    return (cycles >= 1) && (cycles < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/lna_power_sequencer_if.sv
// Bus between radio control (master) and the supply sequencer (slave).
//  RxRequest/TxRequest/Abort : per-channel level requests from radio control
//  EnableReceive/EnableTransmit : supply-switch enables to the LNA/PA switches
//  ReceiveReady/TransmitReady : per-channel settled status
//  Busy       : any channel ramping or in its guard interval
//  chan_state : per-channel FSM state, debug visibility only
// All slave outputs are decoded from registered state; none follows the
// request inputs combinationally, so the requests carry no valid/ready
// handshake -- they are plain levels sampled on every rising clock edge.
interface lna_power_sequencer_if
  import lna_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);
  logic [NUM_CH-1:0]              RxRequest;
  logic [NUM_CH-1:0]              TxRequest;
  logic [NUM_CH-1:0]              Abort;
  logic [NUM_CH-1:0]              EnableReceive;
  logic [NUM_CH-1:0]              EnableTransmit;
  logic [NUM_CH-1:0]              ReceiveReady;
  logic [NUM_CH-1:0]              TransmitReady;
  logic                           Busy;
  logic [NUM_CH-1:0][STATE_W-1:0] chan_state;

  modport master (
    output RxRequest, TxRequest, Abort,
    input  EnableReceive, EnableTransmit, ReceiveReady, TransmitReady, Busy, chan_state
  );

  modport slave (
    input  RxRequest, TxRequest, Abort,
    output EnableReceive, EnableTransmit, ReceiveReady, TransmitReady, Busy, chan_state
  );
endinterface

// File: rtl/lna_chan_fsm.sv
// One RF channel: Moore FSM plus settle/guard down-counter.
//  clk, rst_n       : clock, synchronous active-low reset
//  rx_req, tx_req   : level requests; tx wins when both are set from idle/guard
//  abort            : forces IDLE next cycle, no guard interval
//  en_rx, en_tx     : supply-switch enables (never both high)
//  rx_ready, tx_ready : high only in the *_ON states
//  busy             : channel is ramping or guarding
//  state            : current FSM state for debug
module lna_chan_fsm
  import lna_seq_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RX_SETTLE = DEF_RX_SETTLE,
  parameter int TX_SETTLE = DEF_TX_SETTLE,
  parameter int GUARD     = DEF_GUARD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_req,
  input  logic        tx_req,
  input  logic        abort,
  output logic        en_rx,
  output logic        en_tx,
  output logic        rx_ready,
  output logic        tx_ready,
  output logic        busy,
  output chan_state_t state
);

  // Counter is loaded with N-1 on entry so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] RX_LOAD    = CNT_W'(RX_SETTLE - 1);
  localparam logic [CNT_W-1:0] TX_LOAD    = CNT_W'(TX_SETTLE - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD - 1);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_req) begin
            state_d = ST_TX_RAMP;
            cnt_d   = TX_LOAD;
          end else if (rx_req) begin
            state_d = ST_RX_RAMP;
            cnt_d   = RX_LOAD;
          end
        end
        ST_RX_RAMP: begin
          if (!rx_req || tx_req) begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LOAD;
          end else if (cnt_zero) begin
            state_d = ST_RX_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RX_ON: begin
          if (!rx_req || tx_req) begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LOAD;
          end
        end
        ST_TX_RAMP: begin
          if (!tx_req) begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LOAD;
          end else if (cnt_zero) begin
            state_d = ST_TX_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_TX_ON: begin
          if (!tx_req) begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LOAD;
          end
        end
        ST_GUARD: begin
          // At expiry the channel decides exactly as it would from IDLE.
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else if (tx_req) begin
            state_d = ST_TX_RAMP;
            cnt_d   = TX_LOAD;
          end else if (rx_req) begin
            state_d = ST_RX_RAMP;
            cnt_d   = RX_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign en_rx    = (state_q == ST_RX_RAMP) || (state_q == ST_RX_ON);
  assign en_tx    = (state_q == ST_TX_RAMP) || (state_q == ST_TX_ON);
  assign rx_ready = (state_q == ST_RX_ON);
  assign tx_ready = (state_q == ST_TX_ON);
  assign busy     = (state_q == ST_RX_RAMP) || (state_q == ST_TX_RAMP) ||
                    (state_q == ST_GUARD);
  assign state    = state_q;

endmodule

// File: rtl/lna_power_sequencer.sv
// Per-channel LNA/PA supply sequencer for the RF front end.
//  Clock  : single rising-edge clock
//  ResetN : synchronous active-low reset
//  bus    : slave side of lna_power_sequencer_if (requests in, enables/ready/Busy out)
// Channels are fully independent; Busy is the OR of each channel's
// registered ramp/guard status.
module lna_power_sequencer
  import lna_seq_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RX_SETTLE = DEF_RX_SETTLE,
  parameter int TX_SETTLE = DEF_TX_SETTLE,
  parameter int GUARD     = DEF_GUARD
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  lna_power_sequencer_if.slave  bus
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("lna_power_sequencer: NUM_CH must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
    $error("lna_power_sequencer: CNT_W must be in 1..30");
  end
  if (!cycles_fit(RX_SETTLE, CNT_W)) begin : g_bad_rx_settle
    $error("lna_power_sequencer: RX_SETTLE must be >=1 and < 2**CNT_W");
  end
  if (!cycles_fit(TX_SETTLE, CNT_W)) begin : g_bad_tx_settle
    $error("lna_power_sequencer: TX_SETTLE must be >=1 and < 2**CNT_W");
  end
  if (!cycles_fit(GUARD, CNT_W)) begin : g_bad_guard
    $error("lna_power_sequencer: GUARD must be >=1 and < 2**CNT_W");
  end

  logic [NUM_CH-1:0]              en_rx_v;
  logic [NUM_CH-1:0]              en_tx_v;
  logic [NUM_CH-1:0]              rx_ready_v;
  logic [NUM_CH-1:0]              tx_ready_v;
  logic [NUM_CH-1:0]              busy_v;
  logic [NUM_CH-1:0][STATE_W-1:0] state_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    chan_state_t st;

    lna_chan_fsm #(
      .CNT_W     (CNT_W),
      .RX_SETTLE (RX_SETTLE),
      .TX_SETTLE (TX_SETTLE),
      .GUARD     (GUARD)
    ) u_chan (
      .clk      (Clock),
      .rst_n    (ResetN),
      .rx_req   (bus.RxRequest[i]),
      .tx_req   (bus.TxRequest[i]),
      .abort    (bus.Abort[i]),
      .en_rx    (en_rx_v[i]),
      .en_tx    (en_tx_v[i]),
      .rx_ready (rx_ready_v[i]),
      .tx_ready (tx_ready_v[i]),
      .busy     (busy_v[i]),
      .state    (st)
    );

    assign state_v[i] = st;
  end

  assign bus.EnableReceive  = en_rx_v;
  assign bus.EnableTransmit = en_tx_v;
  assign bus.ReceiveReady   = rx_ready_v;
  assign bus.TransmitReady  = tx_ready_v;
  assign bus.Busy           = |busy_v;
  assign bus.chan_state     = state_v;

endmodule
